gate_truth_table_checker: RTL and testbench

- Synthesizable, self-running checker for small combinational gates (e.g. a 3-input AND) on the lab board.
- Sweeps every input vector from 0 to 2^N_IN-1 and drives it to the gate under test.
- Samples the gate output after a hold interval and compares it with the expected result for the selected gate function.
- Reports a mismatch count, the first failing vector and a pass/fail verdict. It is the hardware response-checking counterpart of a stimulus-only bench.

---
 rtl/gate_truth_table_checker_if.sv | 35 +++
 rtl/gate_truth_table_checker.sv | 131 +++++++++++++
 tb/tb_gate_truth_table_checker.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/gate_truth_table_checker_if.sv
// Bus between the truth-table checker and whatever hosts it (board logic
// or a bench). The checker sits on the slave side, and the host sits on the
// master side.
//
// Handshake: start is a single-cycle request. It is accepted only while busy
// is low, which means in IDLE or DONE. busy rises on the cycle after an
// accepted start. done and the result fields (pass, err_cnt, fail_valid,
// fail_vec) are valid from the cycle done rises until the next accepted
// start. A start seen while busy is dropped. There is no back-pressure.
interface gate_truth_table_checker_if #(
    parameter int N_IN  = 3,
    parameter int ERR_W = 8
);
    logic             start;
    logic [1:0]       gate_sel;
    logic             dut_y;
    logic [N_IN-1:0]  vec_out;
    logic             busy;
    logic             done;
    logic             pass;
    logic [ERR_W-1:0] err_cnt;
    logic             fail_valid;
    logic [N_IN-1:0]  fail_vec;
    logic [1:0]       fsm_state;

    modport master (
        output start, gate_sel, dut_y,
        input  vec_out, busy, done, pass, err_cnt, fail_valid, fail_vec, fsm_state
    );

    modport slave (
        input  start, gate_sel, dut_y,
        output vec_out, busy, done, pass, err_cnt, fail_valid, fail_vec, fsm_state
    );
endinterface

// File: rtl/gate_truth_table_checker.sv
// gate_truth_table_checker: sweeps every input vector of a small combinational
// gate and holds each one for HOLD_CYCLES clocks. On the last hold cycle it
// compares the gate response with the expected function selected at start.
// It reports a saturating mismatch count, the first failing vector and a
// pass verdict.
//
// Optional build macro STOP_ON_FAIL_EN: when it is defined, the first
// mismatch ends the sweep on that sample edge. When it is undefined, the
// sweep always runs to the all-ones vector.
//
// fsm_state exposes the controller state (0=IDLE, 1=RUN, 2=DONE).
module gate_truth_table_checker #(
    parameter int N_IN        = 3,
    parameter int HOLD_CYCLES = 10,
    parameter int ERR_W       = 8
) (
    input logic clk,
    input logic rst_n,
    gate_truth_table_checker_if.slave bus
);

    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [N_IN-1:0]   VEC_LAST  = {N_IN{1'b1}};
    localparam logic [ERR_W-1:0]  ERR_MAX   = {ERR_W{1'b1}};

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]        state;
    logic [N_IN-1:0]   vec_q;
    logic [HOLD_W-1:0] hold_cnt;
    logic [ERR_W-1:0]  err_q;
    logic              fail_valid_q;
    logic [N_IN-1:0]   fail_vec_q;
    logic              pass_q;
    logic [1:0]        sel_q;

    logic              expected;
    logic              sample;
    logic              mismatch;
    logic [ERR_W-1:0]  err_next;
    logic              sweep_end;

    // Reference response of the selected gate for the vector currently driven
    always_comb begin
        expected = 1'b0;
        case (sel_q)
            2'b00:   expected = &vec_q;
            2'b01:   expected = |vec_q;
            2'b10:   expected = ^vec_q;
            default: expected = ~&vec_q;
        endcase
    end

    // Sample-edge decode, saturating error update and end-of-sweep condition
    always_comb begin
        sample   = (state == ST_RUN) && (hold_cnt == HOLD_LAST);
        mismatch = sample && (bus.dut_y != expected);
        err_next = err_q;
        if (mismatch && (err_q != ERR_MAX)) begin
            err_next = err_q + 1'b1;
        end
`ifdef STOP_ON_FAIL_EN
        sweep_end = mismatch || (vec_q == VEC_LAST);
`else
        sweep_end = (vec_q == VEC_LAST);
`endif
    end

    // Sweep controller: start acceptance, vector stepping, result capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            vec_q        <= '0;
            hold_cnt     <= '0;
            err_q        <= '0;
            fail_valid_q <= 1'b0;
            fail_vec_q   <= '0;
            pass_q       <= 1'b0;
            sel_q        <= 2'b00;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (bus.start) begin
                        state        <= ST_RUN;
                        vec_q        <= '0;
                        hold_cnt     <= '0;
                        err_q        <= '0;
                        fail_valid_q <= 1'b0;
                        fail_vec_q   <= '0;
                        pass_q       <= 1'b0;
                        sel_q        <= bus.gate_sel;
                    end
                end
                ST_RUN: begin
                    if (!sample) begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end else begin
                        err_q <= err_next;
                        if (mismatch && !fail_valid_q) begin
                            fail_valid_q <= 1'b1;
                            fail_vec_q   <= vec_q;
                        end
                        // The terminal check comes before the increment, so
                        // vec_out never wraps and holds its last value in DONE.
                        if (sweep_end) begin
                            state  <= ST_DONE;
                            pass_q <= (err_next == '0);
                        end else begin
                            vec_q    <= vec_q + 1'b1;
                            hold_cnt <= '0;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.vec_out    = vec_q;
    assign bus.busy       = (state == ST_RUN);
    assign bus.done       = (state == ST_DONE);
    assign bus.pass       = pass_q;
    assign bus.err_cnt    = err_q;
    assign bus.fail_valid = fail_valid_q;
    assign bus.fail_vec   = fail_vec_q;
    assign bus.fsm_state  = state;

endmodule

// File: tb/tb_gate_truth_table_checker.sv
// Bench for gate_truth_table_checker. It runs two instances: a main one with
// ERR_W=8 and a narrow one with ERR_W=2 to exercise counter saturation. The
// gate under test is a behavioural model chosen by a mode variable. Each
// expected sweep result is pushed into exp_q when a start is driven and is
// popped when done rises.
module tb_gate_truth_table_checker;

    localparam int N_IN = 3;
    localparam int HOLD = 10;
    localparam int W    = 24;

    // Model modes for the gate under test
    localparam int M_AND   = 0;
    localparam int M_STUCK = 1;
    localparam int M_NAND  = 2;
    localparam int M_XOR   = 3;

    logic clk;
    logic rst_n;
    int   mode_a;

    gate_truth_table_checker_if #(.N_IN(N_IN), .ERR_W(8)) bus_a ();
    gate_truth_table_checker_if #(.N_IN(N_IN), .ERR_W(2)) bus_b ();

    logic [W-1:0] exp_q[$];
    int n_checks;
    int n_errors;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- gate models ----------------
    function automatic logic model_y(input int mode, input logic [N_IN-1:0] v);
        case (mode)
            M_AND:   return &v;
            M_STUCK: return 1'b0;
            M_NAND:  return ~&v;
            default: return ^v;
        endcase
    endfunction

    assign bus_a.dut_y = model_y(mode_a, bus_a.vec_out);
    assign bus_b.dut_y = model_y(M_NAND, bus_b.vec_out);

    gate_truth_table_checker #(.N_IN(N_IN), .HOLD_CYCLES(HOLD), .ERR_W(8)) dut_a (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus_a)
    );

    gate_truth_table_checker #(.N_IN(N_IN), .HOLD_CYCLES(HOLD), .ERR_W(2)) dut_b (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus_b)
    );

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Expected word: [23:16] cycles from RUN entry to done, [15:13] final vec,
    // [12] pass, [11] fail_valid, [10:8] fail_vec, [7:0] err_cnt.
    function automatic logic [W-1:0] ref_sweep(input int mode, input logic [1:0] sel,
                                               input int err_max);
        int             err;
        int             last;
        logic           fv;
        logic [N_IN-1:0] fvec;
        logic [N_IN-1:0] vv;
        logic           want;
        logic           pass_e;
        err  = 0;
        last = (1 << N_IN) - 1;
        fv   = 1'b0;
        fvec = '0;
        for (int v = 0; v < (1 << N_IN); v++) begin
            vv = v[N_IN-1:0];
            case (sel)
                2'b00:   want = (vv == 3'b111);
                2'b01:   want = (vv != 3'b000);
                2'b10:   want = vv[0] ^ vv[1] ^ vv[2];
                default: want = (vv != 3'b111);
            endcase
            if (model_y(mode, vv) != want) begin
                if (err < err_max) err++;
                if (!fv) begin
                    fv   = 1'b1;
                    fvec = vv;
                end
`ifdef STOP_ON_FAIL_EN
                last = v;
                break;
`endif
            end
        end
        pass_e = (err == 0);
        return {8'((last + 1) * HOLD), 3'(last), pass_e, fv, fvec, 8'(err)};
    endfunction

    // ---------------- drivers ----------------
    task automatic run_sweep_a(input string tag, input int mode, input logic [1:0] sel,
                               input bit inject);
        logic [W-1:0] e;
        int n;
        mode_a = mode;
        exp_q.push_back(ref_sweep(mode, sel, 255));
        @(posedge clk); #1;
        bus_a.start    = 1'b1;
        bus_a.gate_sel = sel;
        @(posedge clk); #1;
        bus_a.start    = 1'b0;
        bus_a.gate_sel = 2'($urandom_range(0, 3));
        check({tag, ".busy"}, 32'(bus_a.busy), 32'd1);
        n = 0;
        while (!bus_a.done && n < 200) begin
            @(posedge clk); #1;
            n++;
            if (inject && n == 45) begin
                bus_a.start    = 1'b1;
                bus_a.gate_sel = ~sel;
            end
            if (inject && n == 46) bus_a.start = 1'b0;
            if ((n % HOLD) == 5 && bus_a.busy)
                check({tag, ".vec_step"}, 32'(bus_a.vec_out), 32'(n / HOLD));
        end
        e = exp_q.pop_front();
        check({tag, ".cycles"},     32'(n),                32'(e[23:16]));
        check({tag, ".vec_final"},  32'(bus_a.vec_out),    32'(e[15:13]));
        check({tag, ".pass"},       32'(bus_a.pass),       32'(e[12]));
        check({tag, ".fail_valid"}, 32'(bus_a.fail_valid), 32'(e[11]));
        check({tag, ".fail_vec"},   32'(bus_a.fail_vec),   32'(e[10:8]));
        check({tag, ".err_cnt"},    32'(bus_a.err_cnt),    32'(e[7:0]));
        // Results must hold while DONE lasts
        repeat (5) @(posedge clk);
        #1;
        check({tag, ".hold_done"}, 32'(bus_a.done),    32'd1);
        check({tag, ".hold_err"},  32'(bus_a.err_cnt), 32'(e[7:0]));
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [W-1:0] e;
        int n;
        n_checks = 0;
        n_errors = 0;
        mode_a = M_AND;
        rst_n = 1'b0;
        bus_a.start = 1'b0;
        bus_a.gate_sel = 2'b00;
        bus_b.start = 1'b0;
        bus_b.gate_sel = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        check("rst.busy",    32'(bus_a.busy),       32'd0);
        check("rst.done",    32'(bus_a.done),       32'd0);
        check("rst.pass",    32'(bus_a.pass),       32'd0);
        check("rst.vec",     32'(bus_a.vec_out),    32'd0);
        check("rst.err",     32'(bus_a.err_cnt),    32'd0);
        check("rst.fvalid",  32'(bus_a.fail_valid), 32'd0);
        check("rst.fvec",    32'(bus_a.fail_vec),   32'd0);
        check("rst.state",   32'(bus_a.fsm_state),  32'd0);
        rst_n = 1'b1;

        run_sweep_a("and_ok",  M_AND,   2'b00, 1'b0);
        run_sweep_a("stuck0",  M_STUCK, 2'b00, 1'b0);
        run_sweep_a("nand",    M_NAND,  2'b00, 1'b0);
        run_sweep_a("xor_ok",  M_XOR,   2'b10, 1'b0);
        run_sweep_a("xor_or",  M_XOR,   2'b01, 1'b0);
        run_sweep_a("inject",  M_AND,   2'b00, 1'b1);

        // Saturating counter on the narrow instance
        exp_q.push_back(ref_sweep(M_NAND, 2'b00, 3));
        @(posedge clk); #1;
        bus_b.start = 1'b1;
        @(posedge clk); #1;
        bus_b.start = 1'b0;
        n = 0;
        while (!bus_b.done && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        e = exp_q.pop_front();
        check("sat.cycles",  32'(n),             32'(e[23:16]));
        check("sat.err_cnt", 32'(bus_b.err_cnt), 32'(e[7:0]));
        check("sat.pass",    32'(bus_b.pass),    32'(e[12]));

        // Asynchronous abort in the middle of vector 5
        mode_a = M_AND;
        @(posedge clk); #1;
        bus_a.start = 1'b1;
        @(posedge clk); #1;
        bus_a.start = 1'b0;
        repeat (55) @(posedge clk);
        #1;
        check("abort.pre_vec", 32'(bus_a.vec_out), 32'd5);
        #2 rst_n = 1'b0;
        #1;
        check("abort.busy",  32'(bus_a.busy),      32'd0);
        check("abort.vec",   32'(bus_a.vec_out),   32'd0);
        check("abort.done",  32'(bus_a.done),      32'd0);
        check("abort.state", 32'(bus_a.fsm_state), 32'd0);
        check("abort.err",   32'(bus_b.err_cnt),   32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("abort.q_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
